// File: rtl/locked_reg_pkg.sv
// Shared types and default parameters for the lock-gated debug read path.
package locked_reg_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } lock_state_e;

  localparam int          DEF_DATA_W     = 6;
  localparam int          DEF_DEPTH      = 4;
  localparam logic [5:0]  DEF_UNLOCK_KEY = 6'h2A;
  localparam int          DEF_MAX_FAIL   = 3;

endpackage

// File: rtl/locked_reg_reader_lock_ctrl_fsm.sv
// Lock controller: key compare, saturating fail counter, relock and permanent lockout.
module lock_ctrl_fsm
  import locked_reg_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [DATA_W-1:0] UNLOCK_KEY = DEF_UNLOCK_KEY,
  parameter int                MAX_FAIL   = DEF_MAX_FAIL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_key_valid,
  input  logic [DATA_W-1:0] i_key_data,
  input  logic              i_relock,
  output lock_state_e       o_state,
  output logic              o_locked,
  output logic              o_lockout
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  lock_state_e       r_state;
  logic [FAIL_W-1:0] r_fail;
  logic              r_locked;
  logic              r_lockout;

  // relock takes priority over a key in the same cycle, so that key never counts as a failure
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= LOCKED;
      r_fail    <= '0;
      r_locked  <= 1'b1;
      r_lockout <= 1'b0;
    end else begin
      case (r_state)
        LOCKED: begin
          if (i_relock) begin
            r_fail <= '0;
          end else if (i_key_valid) begin
            if (i_key_data == UNLOCK_KEY) begin
              r_state  <= UNLOCKED;
              r_fail   <= '0;
              r_locked <= 1'b0;
            end else if (r_fail >= FAIL_W'(MAX_FAIL - 1)) begin
              r_state   <= LOCKOUT;
              r_fail    <= FAIL_W'(MAX_FAIL);
              r_lockout <= 1'b1;
            end else begin
              r_fail <= r_fail + FAIL_W'(1);
            end
          end
        end
        UNLOCKED: begin
          if (i_relock) begin
            r_state  <= LOCKED;
            r_fail   <= '0;
            r_locked <= 1'b1;
          end
        end
        LOCKOUT: begin
          r_locked  <= 1'b1;
          r_lockout <= 1'b1;
        end
        default: begin
          r_state   <= LOCKED;
          r_fail    <= '0;
          r_locked  <= 1'b1;
          r_lockout <= 1'b0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_locked  = r_locked;
  assign o_lockout = r_lockout;

endmodule

// File: rtl/locked_reg_reader.sv
// Debug read port onto a protected register bank; reads are refused unless the lock FSM is UNLOCKED.
module locked_reg_reader
  import locked_reg_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                DEPTH      = DEF_DEPTH,
  localparam int               ADDR_W     = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] UNLOCK_KEY = DEF_UNLOCK_KEY,
  parameter int                MAX_FAIL   = DEF_MAX_FAIL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  input  logic              relock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              locked_o,
  output logic              lockout_o
);

  lock_state_e       w_state;
  logic              w_accept;
  logic [DATA_W-1:0] r_bank [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  lock_ctrl_fsm #(
    .DATA_W     (DATA_W),
    .UNLOCK_KEY (UNLOCK_KEY),
    .MAX_FAIL   (MAX_FAIL)
  ) u_lock (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_key_valid (key_valid),
    .i_key_data  (key_data),
    .i_relock    (relock),
    .o_state     (w_state),
    .o_locked    (locked_o),
    .o_lockout   (lockout_o)
  );

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (wr_en) begin
      r_bank[wr_addr] <= wr_data;
    end
  end

  // Lock state and bank are sampled pre-edge, so a same-cycle write or relock cannot affect this read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= (w_state != UNLOCKED);
      r_rsp_data  <= (w_state == UNLOCKED) ? r_bank[req_addr] : '0;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_locked_reg_reader.sv
// Directed scenarios followed by random traffic, all checked against a behavioural reference model.
module tb_locked_reg_reader;

  localparam logic [5:0] KEY = 6'h2A;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [5:0] key_data;
  logic       relock;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_data;
  logic       rsp_err;
  logic       locked_o;
  logic       lockout_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit         m_known = 1'b0;
  bit         m_unl, m_lko;
  int         m_fails;
  logic [5:0] m_bank [4];
  bit         m_vld, m_err;
  logic [5:0] m_data;
  logic [5:0] held;

  always #5 clk = ~clk;

  locked_reg_reader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_data  (key_data),
    .relock    (relock),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .locked_o  (locked_o),
    .lockout_o (lockout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset_n = 1'b1; key_valid = 1'b0; key_data = '0; relock = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
  endtask

  // One clock: check handshake, advance the model by the rules, clock, check outputs.
  task automatic step();
    bit acc;
    #1;
    if (m_known) chk("req_ready", 32'(req_ready), 32'(!m_vld || rsp_ready));
    if (!reset_n) begin
      m_known = 1'b1; m_unl = 1'b0; m_lko = 1'b0; m_fails = 0;
      m_vld = 1'b0; m_err = 1'b0; m_data = '0;
      for (int i = 0; i < 4; i++) m_bank[i] = '0;
    end else begin
      acc = req_valid && (!m_vld || rsp_ready);
      if (acc) begin
        m_vld  = 1'b1;
        m_err  = !m_unl;
        m_data = m_unl ? m_bank[req_addr] : 6'h00;
      end else if (rsp_ready) begin
        m_vld = 1'b0;
      end
      if (!m_lko) begin
        if (relock) begin
          m_unl = 1'b0; m_fails = 0;
        end else if (key_valid && !m_unl) begin
          if (key_data == KEY) begin
            m_unl = 1'b1; m_fails = 0;
          end else begin
            m_fails++;
            if (m_fails >= 3) m_lko = 1'b1;
          end
        end
      end
      if (wr_en) m_bank[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
    chk("locked_o", 32'(locked_o), 32'(!m_unl || m_lko));
    chk("lockout_o", 32'(lockout_o), 32'(m_lko));
    if (m_vld) begin
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
    end
  endtask

  initial begin
    idle();
    // 1: reset, then a read with no key is refused
    reset_n = 1'b0;
    step(); step();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_locked", 32'(locked_o), 32'd1);
    chk("reset_lockout", 32'(lockout_o), 32'd0);
    idle(); req_valid = 1'b1; req_addr = 2'd0;
    step();
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_err", 32'(rsp_err), 32'd1);
    chk("t1_data", 32'(rsp_data), 32'd0);
    chk("t1_locked", 32'(locked_o), 32'd1);

    // 2: write, unlock, read back
    idle(); wr_en = 1'b1; wr_addr = 2'd2; wr_data = 6'h15; step();
    idle(); key_valid = 1'b1; key_data = KEY; step();
    idle(); req_valid = 1'b1; req_addr = 2'd2; step();
    chk("t2_data", 32'(rsp_data), 32'h15);
    chk("t2_err", 32'(rsp_err), 32'd0);
    chk("t2_locked", 32'(locked_o), 32'd0);

    // 3: three wrong keys lock out; correct key then ignored; reset recovers
    idle(); relock = 1'b1; step();
    for (int i = 0; i < 3; i++) begin
      idle(); key_valid = 1'b1; key_data = 6'h01; step();
    end
    chk("t3_lockout", 32'(lockout_o), 32'd1);
    idle(); key_valid = 1'b1; key_data = KEY; step();
    chk("t3_stay_lockout", 32'(lockout_o), 32'd1);
    chk("t3_stay_locked", 32'(locked_o), 32'd1);
    idle(); reset_n = 1'b0; step();
    chk("t3_reset_lockout", 32'(lockout_o), 32'd0);
    chk("t3_reset_locked", 32'(locked_o), 32'd1);

    // 4: stalled response holds data and blocks requests; release accepts at once
    idle(); key_valid = 1'b1; key_data = KEY; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 6'h15; step();
    idle(); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 6'h0B; req_valid = 1'b1; req_addr = 2'd2;
    rsp_ready = 1'b0; step();
    held = rsp_data;
    chk("t4_first", 32'(rsp_data), 32'h15);
    for (int i = 0; i < 3; i++) begin
      idle(); req_valid = 1'b1; req_addr = 2'd1; rsp_ready = 1'b0;
      #1 chk("t4_ready_low", 32'(req_ready), 32'd0);
      step();
      chk("t4_stable", 32'(rsp_data), 32'(held));
    end
    idle(); req_valid = 1'b1; req_addr = 2'd1; rsp_ready = 1'b1;
    #1 chk("t4_ready_release", 32'(req_ready), 32'd1);
    step();
    chk("t4_next_data", 32'(rsp_data), 32'h0B);

    // 5: same-cycle write and relock do not affect the accepted read
    idle(); req_valid = 1'b1; req_addr = 2'd1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 6'h3F;
    relock = 1'b1; step();
    chk("t5_old_data", 32'(rsp_data), 32'h0B);
    chk("t5_err", 32'(rsp_err), 32'd0);
    idle(); req_valid = 1'b1; req_addr = 2'd1; step();
    chk("t5_next_err", 32'(rsp_err), 32'd1);
    chk("t5_next_data", 32'(rsp_data), 32'd0);

    // 6: reset drops a pending response
    idle(); req_valid = 1'b1; rsp_ready = 1'b0; step();
    chk("t6_pending", 32'(rsp_valid), 32'd1);
    idle(); reset_n = 1'b0; rsp_ready = 1'b0; step();
    chk("t6_dropped", 32'(rsp_valid), 32'd0);
    chk("t6_locked", 32'(locked_o), 32'd1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      reset_n   = ($urandom_range(0, 99) != 0);
      key_valid = ($urandom_range(0, 3) == 0);
      key_data  = ($urandom_range(0, 1) == 0) ? KEY : 6'($urandom);
      relock    = ($urandom_range(0, 11) == 0);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = 2'($urandom);
      wr_data   = 6'($urandom);
      req_valid = ($urandom_range(0, 1) == 0);
      req_addr  = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
